// File: rtl/maze_run_controller.sv
// Game-level sequencer for the maze: owns the player position, lives,
// move counter and the IDLE/PLAY/PAUSED/DEAD/WIN/LOSE state machine.
module maze_run_controller #(
  parameter int COLS     = 18,
  parameter int CELLS    = 198,
  parameter int LIVES    = 3,
  parameter int DEAD_POS = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             move_tick,
  input  logic             UPbtn,
  input  logic             DOWNbtn,
  input  logic             RIGHTbtn,
  input  logic             LEFTbtn,
  input  logic             CTRLbtn,
  input  logic [CELLS-1:0] mazestate,
  input  logic [7:0]       begin_spot,
  input  logic [7:0]       end_spot,
  output logic [7:0]       pos,
  output logic [2:0]       game_state,
  output logic [1:0]       lives,
  output logic [9:0]       move_count,
  output logic             game_active
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    PAUSED = 3'd2,
    DEAD   = 3'd3,
    WIN    = 3'd4,
    LOSE   = 3'd5
  } state_e;

  localparam logic [8:0] CELLS9 = 9'(CELLS);
  localparam logic [7:0] COLS8  = 8'(COLS);
  localparam logic [7:0] DEAD8  = 8'(DEAD_POS);
  localparam logic [1:0] LIVES2 = 2'(LIVES);

  state_e      state_q, state_d;
  logic [7:0]  pos_q, pos_d;
  logic [1:0]  lives_q, lives_d;
  logic [9:0]  mc_q, mc_d;
  logic        ctrl_q;
  logic        active_q;

  logic        ctrl_rise;
  logic        spawn_ok;
  logic        dir_any;
  logic        edge_hit;
  logic        hit;
  logic [8:0]  cand9;
  logic [7:0]  col;

  assign ctrl_rise = CTRLbtn & ~ctrl_q;
  assign spawn_ok  = ({1'b0, begin_spot} < CELLS9)
                   && mazestate[begin_spot];

  // Candidate cell is kept 9 bits wide so DOWN never wraps.
  always_comb begin
    col      = pos_q % COLS8;
    cand9    = {1'b0, pos_q};
    edge_hit = 1'b0;
    dir_any  = 1'b1;
    priority case (1'b1)
      UPbtn: begin
        cand9    = {1'b0, pos_q} - {1'b0, COLS8};
        edge_hit = pos_q < COLS8;
      end
      DOWNbtn: begin
        cand9    = {1'b0, pos_q} + {1'b0, COLS8};
        edge_hit = cand9 >= CELLS9;
      end
      RIGHTbtn: begin
        cand9    = {1'b0, pos_q} + 9'd1;
        edge_hit = col == COLS8 - 8'd1;
      end
      LEFTbtn: begin
        cand9    = {1'b0, pos_q} - 9'd1;
        edge_hit = col == 8'd0;
      end
      default: dir_any = 1'b0;
    endcase
    hit = edge_hit || (cand9 >= CELLS9)
        || !mazestate[cand9[7:0]];
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    lives_d = lives_q;
    mc_d    = mc_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_rise && spawn_ok) begin
          state_d = PLAY;
          pos_d   = begin_spot;
          lives_d = LIVES2;
          mc_d    = '0;
        end
      end
      PLAY: begin
        if (ctrl_rise) begin
          state_d = PAUSED;
        end else if (move_tick && dir_any) begin
          if (hit) begin
            pos_d   = DEAD8;
            lives_d = lives_q - 2'd1;
            state_d = (lives_d == 2'd0) ? LOSE : DEAD;
          end else begin
            pos_d = cand9[7:0];
            if (mc_q != 10'h3FF) mc_d = mc_q + 10'd1;
            if (cand9[7:0] == end_spot) state_d = WIN;
          end
        end
      end
      PAUSED: begin
        if (ctrl_rise) state_d = PLAY;
      end
      DEAD: begin
        if (ctrl_rise) begin
          if (spawn_ok) begin
            state_d = PLAY;
            pos_d   = begin_spot;
          end else begin
            state_d = LOSE;
          end
        end
      end
      WIN, LOSE: begin
        if (ctrl_rise) begin
          state_d = IDLE;
          pos_d   = DEAD8;
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = DEAD8;
      end
    endcase
  end

  // ctrl_q resets high so a button held through reset is not an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pos_q    <= DEAD8;
      lives_q  <= '0;
      mc_q     <= '0;
      ctrl_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      lives_q  <= lives_d;
      mc_q     <= mc_d;
      ctrl_q   <= CTRLbtn;
      active_q <= (state_d == PLAY);
    end
  end

  assign pos         = pos_q;
  assign game_state  = state_q;
  assign lives       = lives_q;
  assign move_count  = mc_q;
  assign game_active = active_q;

endmodule

// File: tb/tb_maze_run_controller.sv
// Directed bench for maze_run_controller: vector table plus
// hand sequences for reset, edges, respawn and saturation.
module tb_maze_run_controller;

  logic         CLK = 1'b0;
  logic         RST;
  logic         move_tick, UPbtn, DOWNbtn, RIGHTbtn, LEFTbtn, CTRLbtn;
  logic [197:0] mazestate;
  logic [7:0]   begin_spot, end_spot;
  logic [7:0]   pos;
  logic [2:0]   game_state;
  logic [1:0]   lives;
  logic [9:0]   move_count;
  logic         game_active;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  maze_run_controller dut (
    .CLK(CLK), .RST(RST), .move_tick(move_tick),
    .UPbtn(UPbtn), .DOWNbtn(DOWNbtn),
    .RIGHTbtn(RIGHTbtn), .LEFTbtn(LEFTbtn),
    .CTRLbtn(CTRLbtn), .mazestate(mazestate),
    .begin_spot(begin_spot), .end_spot(end_spot),
    .pos(pos), .game_state(game_state), .lives(lives),
    .move_count(move_count), .game_active(game_active)
  );

  typedef struct {
    logic       c, t, u, d, r, l;
    logic [2:0] st;
    logic [7:0] p;
    logic [1:0] lv;
    logic [9:0] mc;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic c, t, u, d, r, l,
                              input logic [2:0] st,
                              input logic [7:0] p,
                              input logic [1:0] lv,
                              input logic [9:0] mc);
    vec_t v;
    v.c = c; v.t = t; v.u = u; v.d = d; v.r = r; v.l = l;
    v.st = st; v.p = p; v.lv = lv; v.mc = mc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [2:0] st,
                       input logic [7:0] p, input logic [1:0] lv,
                       input logic [9:0] mc);
    logic act;
    act = (st == 3'd1);
    checks++;
    if (game_state !== st || pos !== p || lives !== lv
        || move_count !== mc || game_active !== act) begin
      errors++;
      $display("FAIL %s: got st=%0d pos=%0d lives=%0d mc=%0d act=%0b, want st=%0d pos=%0d lives=%0d mc=%0d act=%0b",
               nm, game_state, pos, lives, move_count, game_active,
               st, p, lv, mc, act);
    end
  endtask

  task automatic step(input logic c, t, u, d, r, l);
    CTRLbtn = c; move_tick = t;
    UPbtn = u; DOWNbtn = d; RIGHTbtn = r; LEFTbtn = l;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    mazestate = '0;
    mazestate[181] = 1'b1;
    mazestate[163] = 1'b1;
    mazestate[145] = 1'b1;
    mazestate[164] = 1'b1;
    mazestate[182] = 1'b1;
    begin_spot = 8'd181;
    end_spot   = 8'd145;

    //        c  t  u  d  r  l   st  pos  lv  mc
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 255, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 1, 181, 3, 0);
    tbl[2]  = mk(0, 1, 1, 0, 1, 0, 1, 163, 3, 1);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 1, 163, 3, 1);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 1, 163, 3, 1);
    tbl[5]  = mk(0, 1, 0, 0, 1, 0, 1, 164, 3, 2);
    tbl[6]  = mk(0, 1, 0, 0, 0, 1, 1, 163, 3, 3);
    tbl[7]  = mk(1, 1, 0, 1, 0, 0, 2, 163, 3, 3);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0, 2, 163, 3, 3);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1, 163, 3, 3);
    tbl[10] = mk(0, 1, 1, 0, 0, 0, 4, 145, 3, 4);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 255, 3, 4);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 255, 3, 4);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 1, 181, 3, 0);
    tbl[14] = mk(0, 1, 0, 1, 0, 0, 3, 255, 2, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 181, 2, 0);
    tbl[16] = mk(0, 1, 0, 0, 1, 0, 1, 182, 2, 1);
    tbl[17] = mk(0, 1, 0, 0, 1, 0, 3, 255, 1, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 1, 181, 1, 1);
    tbl[19] = mk(0, 1, 0, 0, 0, 1, 5, 255, 0, 1);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 255, 0, 1);

    // Reset with CTRL held: no start until released and pressed.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset", 0, 255, 0, 0);
    RST = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("held_ctrl", 0, 255, 0, 0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].c, tbl[i].t, tbl[i].u, tbl[i].d,
           tbl[i].r, tbl[i].l);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].p,
            tbl[i].lv, tbl[i].mc);
    end

    // Left from column 0 even though cell 179 is open.
    mazestate[180] = 1'b1;
    mazestate[179] = 1'b1;
    begin_spot = 8'd180;
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("start180", 1, 180, 3, 0);
    step(0, 1, 0, 0, 0, 1);
    check("left_col0", 3, 255, 2, 0);
    begin_spot = 8'd181;
    step(1, 0, 0, 0, 0, 0);
    check("respawn", 1, 181, 2, 0);

    // Reset mid-PLAY overrides a move.
    RST = 1'b1;
    step(0, 1, 1, 0, 0, 0);
    check("rst_midplay", 0, 255, 0, 0);
    RST = 1'b0;

    // Right from last column even though cell 18 is open.
    mazestate[17] = 1'b1;
    mazestate[18] = 1'b1;
    begin_spot = 8'd17;
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("start17", 1, 17, 3, 0);
    step(0, 1, 0, 0, 1, 0);
    check("right_edge", 3, 255, 2, 0);
    mazestate[0] = 1'b1;
    begin_spot = 8'd0;
    step(1, 0, 0, 0, 0, 0);
    check("respawn0", 1, 0, 2, 0);
    step(0, 1, 1, 0, 0, 0);
    check("up_top", 3, 255, 1, 0);
    begin_spot = 8'd250;
    step(1, 0, 0, 0, 0, 0);
    check("dead_badspawn", 5, 255, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("lose_ack", 0, 255, 1, 0);

    // Start refused when spawn cell is a wall.
    begin_spot = 8'd181;
    mazestate[181] = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("spawn_wall", 0, 255, 1, 0);
    mazestate[181] = 1'b1;

    // Move counter saturation.
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("start_sat", 1, 181, 3, 0);
    for (int k = 0; k < 1030; k++) begin
      if (k % 2 == 0) step(0, 1, 0, 0, 1, 0);
      else            step(0, 1, 0, 0, 0, 1);
    end
    check("saturate", 1, 181, 3, 1023);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
